// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle for if_prefetch_queue: imem request/response, execute redirect and decode hand-off.
// master = the prefetch queue itself, slave = the surrounding core/memory.
interface if_prefetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc4;
    logic [CW-1:0]   count;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, count,
        input  imem_rdata, redirect_en, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, count,
        output imem_rdata, redirect_en, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// DEPTH-entry instruction prefetch FIFO between imem and decode, with redirect flush.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the arriving imem word straight to decode.
module if_prefetch_queue #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    if_prefetch_queue_if.master  bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_d [DEPTH];

    logic            req;
    logic            resp_ok;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [CW:0]     used;

    always_comb begin
        // Outstanding response occupies a slot so a full queue can never be overrun.
        used       = {1'b0, count_q} + (CW+1)'(inflight_q);
        req        = rst && !bus.redirect_en && (used < (CW+1)'(DEPTH));
        resp_ok    = inflight_q && !kill_q && !bus.redirect_en;
        head_valid = (count_q != '0);

        bus.imem_req  = req;
        bus.imem_addr = fetch_pc_q;
        bus.count     = count_q;
        bus.id_valid  = head_valid;
        bus.id_instr  = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
        bus.id_pc     = head_valid ? pc_mem_q[rd_ptr_q] : '0;
        push          = resp_ok;
`ifdef IFQ_BYPASS_EN
        if (!head_valid && resp_ok) begin
            bus.id_valid = 1'b1;
            bus.id_instr = bus.imem_rdata;
            bus.id_pc    = tag_pc_q;
            push         = !bus.id_ready;
        end
`endif
        bus.id_pc4 = bus.id_pc + XLEN'(4);
        pop        = head_valid && bus.id_ready && !bus.redirect_en;

        fetch_pc_d  = fetch_pc_q;
        tag_pc_d    = tag_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = req;
        kill_d      = bus.redirect_en && req;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        if (req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            tag_pc_d   = fetch_pc_q;
        end
        if (push) begin
            instr_mem_d[wr_ptr_q] = bus.imem_rdata;
            pc_mem_d[wr_ptr_q]    = tag_pc_q;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // push/pop are already suppressed during redirect, so wr_ptr_q is the settled tail.
        if (bus.redirect_en) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            tag_pc_q    <= tag_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            kill_q      <= kill_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised next-generation fetch front end for the pipelined RV32I core.
- Replaces the single-register IF/ID hand-off with a DEPTH-entry prefetch FIFO between instruction memory and decode.
- Decode can stall without losing fetched instructions, and an execute-stage redirect (taken branch or jump) flushes all wrong-path entries.
- Sits between imem and instruction_decode; supplies instruction, PC and PC+4 per entry.

Parameters:
- XLEN, 32: PC/address width.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  XLEN  fetch address; word aligned.
- imem_rdata  input  32  instruction word; valid exactly one cycle after an accepted imem_req.
- redirect_en  input  1  redirect from execute (PCSrcE).
- redirect_pc  input  XLEN  redirect target (PCTargetE).
- id_ready  input  1  decode accepts the head entry.
- id_valid  output  1  head entry valid.
- id_instr  output  32  head instruction.
- id_pc  output  XLEN  head PC.
- id_pc4  output  XLEN  head PC+4.
- count  output  clog2(DEPTH)+1  occupied entries.

Behaviour:
- State:
  - fetch_pc register.
  - FIFO storage of {instr, pc}, with wr_ptr and rd_ptr of clog2(DEPTH) bits wrapping modulo DEPTH.
  - count register.
  - inflight flag (1 bit).
  - kill flag (1 bit).
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; count=0; pointers=0; inflight=0; kill=0.
  - id_valid=0; imem_req=0.
  - When the FIFO is empty, id_instr=32'h00000013 (NOP), id_pc=0, id_pc4=4.
- Credit: credits = DEPTH - count - inflight.
- imem_req = rst && !redirect_en && (credits > 0).
  - imem_addr = fetch_pc.
  - Every request is accepted. On a request, fetch_pc <= fetch_pc+4 (XLEN wrap) and inflight <= 1.
  - Back-to-back requests are allowed. inflight is replaced by the new request as the old response lands in the same cycle.
- Response: in the cycle after a request, imem_rdata is pushed with its issuing PC, unless kill=1 or redirect_en=1 in that cycle, in which case it is dropped.
- Pop: when id_valid && id_ready && !redirect_en, rd_ptr advances and count decrements.
  - A simultaneous push and pop leaves count unchanged.
  - Freed credit is visible next cycle; there is no same-cycle credit reuse.
- Outputs id_instr, id_pc and id_pc4 are taken combinationally from the head entry. id_valid = (count != 0).
- Redirect (redirect_en=1):
  - Next edge: count=0, rd_ptr=wr_ptr, fetch_pc=redirect_pc.
  - kill=1 if a request was issued this cycle, else 0.
  - No request is issued in the redirect cycle.
  - Redirect beats pop and push in the same cycle.
  - Back-to-back redirects: the last one wins.
- Latency (bypass off):
  - Request in cycle N, data in the FIFO at the end of N+1, id_valid in N+2.
  - Steady state: 1 instruction per cycle with id_ready held high.
- Full: count==DEPTH, so credits=0 and no request. This cannot overflow because inflight is counted in credits.
- Empty with id_ready=1: no pop, no underflow.
- Misaligned redirect_pc: bits[1:0] are forced to 0.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When count==0 and a non-killed response arrives, id_valid=1 the same cycle, with id_instr=imem_rdata and PC from the inflight tag.
  - If id_ready=1, the entry is consumed directly and not written; otherwise it is written normally.
  - Fetch-to-decode latency drops to 1 cycle after the request.
- Not defined: no bypass; the 2-cycle latency above applies.

Test Plan:
- Reset, then release with id_ready=1 and RESET_PC=0 -> imem_addr sequence 0,4,8,...; first id_valid two cycles after the first request with id_pc=0; thereafter one entry per cycle, id_pc4=id_pc+4.
- Hold id_ready=0 from reset -> exactly DEPTH=4 requests (0..12), count=4, imem_req=0. Then raise id_ready -> entries pop in order 0,4,8,12 and fetch resumes at 16.
- Redirect to 0x100 while count=3 and a response is in flight -> next cycle count=0; the in-flight word is dropped; first delivered id_pc=0x100.
- Redirect and pop in the same cycle, followed by a second redirect to 0x200 -> no pop occurs; first delivered PC=0x200.
- Fetch at 0xFFFFFFFC -> next imem_addr=0x00000000 (wrap). Redirect to 0x103 -> imem_addr=0x100.
- With IFQ_BYPASS_EN defined and an empty FIFO -> id_valid in the cycle after the request with id_instr=imem_rdata, and count stays 0.
